axi_sram_slave: RTL
===================

# axi_sram_slave

Synthesizable AXI4 responder backing a word-addressed SRAM. It is the slave end of the `fmrv32im_core` MM_AXI master port, and lets core programs and the riscv-tests regressions run against real memory instead of a behavioural model. Read and write channels are independent, one burst outstanding per direction, and the read side gives full beat throughput.

## Interface
- `MEM_AW`, 10: word-address width; depth = 2**MEM_AW 32-bit words.
- `ID_W`, 1: AXI ID width.
- `ACLK` in 1: the single clock.
- `ARESETN` in 1: asynchronous, active-low reset.
- `S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST` in ID_W/32/8/3/2: write address channel.
- `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1: write address handshake.
- `S_AXI_WDATA/WSTRB/WLAST/WVALID` in 32/4/1/1, `S_AXI_WREADY` out 1: write data channel.
- `S_AXI_BID/BRESP/BVALID` out ID_W/2/1, `S_AXI_BREADY` in 1: write response channel.
- `S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST` in ID_W/32/8/3/2: read address channel.
- `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1: read address handshake.
- `S_AXI_RID/RDATA/RRESP/RLAST/RVALID` out ID_W/32/2/1/1, `S_AXI_RREADY` in 1: read data channel.
- `*LOCK/*CACHE/*PROT/*QOS/*USER` inputs: accepted and ignored. `BUSER`/`RUSER` outputs are tied to 0.

## Operation
- Address decode: word index = ADDR[MEM_AW+1:2]. Upper address bits and ADDR[1:0] are ignored. The index wraps modulo the depth.
- Burst support:
  - FIXED (00): every beat uses the same index.
  - INCR (01): the index increments by 1 per beat.
  - WRAP (10) and reserved (11): error burst.
  - SIZE != 3'b010 is also an error burst.
- Error burst behaviour:
  - Every beat completes the handshake.
  - Writes are suppressed.
  - RDATA = 0, RRESP/BRESP = SLVERR (2'b10).
  - Otherwise responses are OKAY.
- Write FSM:
  - W_IDLE: AWREADY = 1. On AW handshake, latch ID, index, LEN, burst and error flag, then go to W_DATA.
  - W_DATA: WREADY = 1. Each W handshake writes the bytes enabled by WSTRB and advances the index and the beat counter. On beat LEN, go to W_RESP.
  - WLAST mismatch: if WLAST is asserted on a beat other than beat LEN, or absent on beat LEN, set the error flag. Data is still written. BRESP = SLVERR.
  - W_RESP: BVALID = 1, BID = latched ID. On BREADY, go to W_IDLE.
- Read FSM:
  - R_IDLE: ARREADY = 1. On AR handshake, latch the burst parameters, issue the memory read and go to R_DATA.
  - R_DATA: RVALID = 1, RID = latched ID, RLAST = (beat == LEN). On each R handshake, advance the index. If RLAST, go to R_IDLE.
  - While RVALID=1 and RREADY=0, RDATA/RRESP/RLAST hold stable.
- Same-word collision: a read and a write to the same word in the same cycle return the old data (read-before-write).

## Timing
- Reset values:
  - All outputs are 0, including AWREADY and ARREADY.
  - Both FSMs are in IDLE, and the ready signals rise on the first ACLK after reset release.
  - Memory contents are not reset.
- Read latency: AR handshake at cycle N gives the first RVALID at N+1. With RREADY held high, beats are back-to-back, so a LEN=k burst completes at N+1+k. ARREADY is next high the cycle after the RLAST handshake.
- Write path:
  - WREADY is high from the cycle after the AW handshake.
  - A write takes effect at the edge of the W handshake.
  - BVALID rises the cycle after the last W handshake.
  - AWREADY rises the cycle after the B handshake.
- The W channel is ignored (WREADY = 0) until AW is accepted; there is no write-data-before-address buffering.
- Reset asserted mid-burst aborts immediately to the reset values. No response is issued for the aborted burst.

## Structure
- `axi_pkg`:
  - Burst constants (FIXED/INCR/WRAP) and resp constants (OKAY/SLVERR).
  - The write and read FSM state enums.
  - A `burst_ctx_t` struct {id, index, len, beat, burst, err}.
- Sub-module `axi_sram_mem`: one write port with 4 byte enables and one synchronous read port. It is inferable as block RAM and supports `$readmemh` preload through the hierarchical array `mem`.

## Test plan
- Single write then read: AW 0x0000_0800, WDATA 0x0000_0001, WSTRB F, then AR 0x800 -> BRESP 0, then RDATA 0x00000001, RLAST=1, RRESP 0.
- INCR write, LEN=3, 0x100, data 0xA0..0xA3 -> INCR read returns 0xA0..0xA3 with RLAST only on the 4th beat, one beat per cycle with RREADY=1.
- Byte strobe: preload 0xFFFFFFFF, write 0x12345678 with WSTRB 4'b0101 -> read 0xFF34FF78.
- RREADY toggled 1/0 during a LEN=7 read -> data stable while stalled, 8 beats, no drop or duplication.
- Error cases:
  - WRAP burst write -> memory unchanged, BRESP 2'b10.
  - ARSIZE=0 -> RRESP 2'b10 and RDATA 0 on every beat.
- ARESETN asserted mid-write after beat 2 of 4 -> outputs 0 on the same edge, BVALID never seen, the next AW is accepted normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state types and per-direction burst context for axi_sram_slave.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_WORD   = 3'b010;

    // Context fields are sized for the widest supported instance; users slice them down.
    localparam int ID_MAX  = 16;
    localparam int IDX_MAX = 32;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    typedef struct packed {
        logic [ID_MAX-1:0]  id;
        logic [IDX_MAX-1:0] index;
        logic [7:0]         len;
        logic [7:0]         beat;
        logic [1:0]         burst;
        logic               err;
    } burst_ctx_t;

    function automatic logic burst_error(input logic [1:0] burst, input logic [2:0] size);
        return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (size != SIZE_WORD);
    endfunction

    function automatic logic [IDX_MAX-1:0] next_index(input burst_ctx_t ctx);
        return (ctx.burst == BURST_INCR) ? ctx.index + 1'b1 : ctx.index;
    endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Word-wide SRAM: one byte-enabled write port, one synchronous read port with hold-on-idle.
module axi_sram_mem #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // NOTE: the array has no reset so it maps onto block RAM; contents are whatever was preloaded or written.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        // NOTE: non-blocking update means a same-cycle read of the written word sees the old data.
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave over a word-addressed SRAM: independent read/write FSMs, one burst per direction.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int ID_W   = 1
) (
    input  logic            ACLK,
    input  logic            ARESETN,
    input  logic [ID_W-1:0] S_AXI_AWID,
    input  logic [31:0]     S_AXI_AWADDR,
    input  logic [7:0]      S_AXI_AWLEN,
    input  logic [2:0]      S_AXI_AWSIZE,
    input  logic [1:0]      S_AXI_AWBURST,
    input  logic            S_AXI_AWLOCK,
    input  logic [3:0]      S_AXI_AWCACHE,
    input  logic [2:0]      S_AXI_AWPROT,
    input  logic [3:0]      S_AXI_AWQOS,
    input  logic            S_AXI_AWUSER,
    input  logic            S_AXI_AWVALID,
    output logic            S_AXI_AWREADY,
    input  logic [31:0]     S_AXI_WDATA,
    input  logic [3:0]      S_AXI_WSTRB,
    input  logic            S_AXI_WLAST,
    input  logic            S_AXI_WUSER,
    input  logic            S_AXI_WVALID,
    output logic            S_AXI_WREADY,
    output logic [ID_W-1:0] S_AXI_BID,
    output logic [1:0]      S_AXI_BRESP,
    output logic            S_AXI_BUSER,
    output logic            S_AXI_BVALID,
    input  logic            S_AXI_BREADY,
    input  logic [ID_W-1:0] S_AXI_ARID,
    input  logic [31:0]     S_AXI_ARADDR,
    input  logic [7:0]      S_AXI_ARLEN,
    input  logic [2:0]      S_AXI_ARSIZE,
    input  logic [1:0]      S_AXI_ARBURST,
    input  logic            S_AXI_ARLOCK,
    input  logic [3:0]      S_AXI_ARCACHE,
    input  logic [2:0]      S_AXI_ARPROT,
    input  logic [3:0]      S_AXI_ARQOS,
    input  logic            S_AXI_ARUSER,
    input  logic            S_AXI_ARVALID,
    output logic            S_AXI_ARREADY,
    output logic [ID_W-1:0] S_AXI_RID,
    output logic [31:0]     S_AXI_RDATA,
    output logic [1:0]      S_AXI_RRESP,
    output logic            S_AXI_RLAST,
    output logic            S_AXI_RUSER,
    output logic            S_AXI_RVALID,
    input  logic            S_AXI_RREADY
);

    w_state_e          w_state, w_state_nxt;
    r_state_e          r_state, r_state_nxt;
    burst_ctx_t        w_ctx, r_ctx;
    logic              w_resp_err;
    logic              ready_en;
    logic              aw_hs, w_hs, ar_hs, r_hs;
    logic              w_last_beat, r_last_beat;
    logic [IDX_MAX-1:0] w_next_index, r_next_index;
    logic              mem_we, mem_re;
    logic [MEM_AW-1:0] mem_raddr;
    logic [31:0]       mem_rdata;

    // Keeps both READY outputs low while reset is held; they rise on the first clock after release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    assign aw_hs        = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs         = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs        = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs         = S_AXI_RVALID  && S_AXI_RREADY;
    assign w_last_beat  = (w_ctx.beat == w_ctx.len);
    assign r_last_beat  = (r_ctx.beat == r_ctx.len);
    assign w_next_index = next_index(w_ctx);
    assign r_next_index = next_index(r_ctx);

    always_comb begin
        w_state_nxt   = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = ready_en;
                if (S_AXI_AWVALID && ready_en) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && w_last_beat) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state    <= W_IDLE;
            w_ctx      <= '0;
            w_resp_err <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_ctx.id    <= ID_MAX'(S_AXI_AWID);
                w_ctx.index <= IDX_MAX'(S_AXI_AWADDR[MEM_AW+1:2]);
                w_ctx.len   <= S_AXI_AWLEN;
                w_ctx.beat  <= '0;
                w_ctx.burst <= S_AXI_AWBURST;
                w_ctx.err   <= burst_error(S_AXI_AWBURST, S_AXI_AWSIZE);
                w_resp_err  <= 1'b0;
            end
            if (w_hs) begin
                w_ctx.index <= w_next_index;
                w_ctx.beat  <= w_ctx.beat + 1'b1;
                // WLAST on the wrong beat, or missing on the final one, poisons the response only.
                if (S_AXI_WLAST != w_last_beat) w_resp_err <= 1'b1;
            end
        end
    end

    assign mem_we      = w_hs && !w_ctx.err;
    assign S_AXI_BID   = w_ctx.id[ID_W-1:0];
    assign S_AXI_BRESP = (S_AXI_BVALID && (w_ctx.err || w_resp_err)) ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        r_state_nxt   = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = ready_en;
                if (S_AXI_ARVALID && ready_en) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY && r_last_beat) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            r_ctx   <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_ctx.id    <= ID_MAX'(S_AXI_ARID);
                r_ctx.index <= IDX_MAX'(S_AXI_ARADDR[MEM_AW+1:2]);
                r_ctx.len   <= S_AXI_ARLEN;
                r_ctx.beat  <= '0;
                r_ctx.burst <= S_AXI_ARBURST;
                r_ctx.err   <= burst_error(S_AXI_ARBURST, S_AXI_ARSIZE);
            end
            if (r_hs) begin
                r_ctx.index <= r_next_index;
                r_ctx.beat  <= r_ctx.beat + 1'b1;
            end
        end
    end

    // The next beat is fetched only on a handshake, so the RAM output register holds during stalls.
    assign mem_re    = ar_hs || (r_hs && !r_last_beat);
    assign mem_raddr = ar_hs ? S_AXI_ARADDR[MEM_AW+1:2] : r_next_index[MEM_AW-1:0];

    assign S_AXI_RID   = r_ctx.id[ID_W-1:0];
    assign S_AXI_RLAST = S_AXI_RVALID && r_last_beat;
    assign S_AXI_RRESP = (S_AXI_RVALID && r_ctx.err) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RDATA = (S_AXI_RVALID && !r_ctx.err) ? mem_rdata : '0;
    assign S_AXI_BUSER = 1'b0;
    assign S_AXI_RUSER = 1'b0;

    axi_sram_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .clk   (ACLK),
        .we    (mem_we),
        .be    (S_AXI_WSTRB),
        .waddr (w_ctx.index[MEM_AW-1:0]),
        .wdata (S_AXI_WDATA),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_AWLOCK, S_AXI_AWCACHE,
                             S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWUSER, S_AXI_WUSER,
                             S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS,
                             S_AXI_ARUSER, w_ctx, r_ctx, w_next_index, r_next_index};

endmodule
